// File: rtl/uf_axis_pkg.sv
// Shared types, tags and beat builders for the union-find AXI-Stream packer.
package uf_axis_pkg;

  localparam logic [3:0] TAG_REC = 4'h1;
  localparam logic [3:0] TAG_TRL = 4'hF;

  localparam int unsigned TagLo    = 60;
  localparam int unsigned FidxLo   = 44;
  localparam int unsigned TruncBit = 40;
  localparam int unsigned FirstBit = 36;

  typedef enum logic [1:0] {StIdle, StStream, StTrailer} state_e;

  function automatic logic [63:0] rec_beat(input logic [15:0] fidx, input logic first,
                                           input logic [35:0] rec);
    rec_beat = '0;
    rec_beat[63:TagLo]       = TAG_REC;
    rec_beat[59:FidxLo]      = fidx;
    rec_beat[FirstBit]       = first;
    rec_beat[35:0]           = rec;
  endfunction

  function automatic logic [63:0] trl_beat(input logic [15:0] fidx, input logic trunc,
                                           input logic [31:0] cnt);
    trl_beat = '0;
    trl_beat[63:TagLo]  = TAG_TRL;
    trl_beat[59:FidxLo] = fidx;
    trl_beat[TruncBit]  = trunc;
    trl_beat[31:0]      = cnt;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uf_pack_fifo.sv
// First-word-fall-through synchronous FIFO; push ignored when full, pop ignored when empty.
module uf_pack_fifo #(
  parameter int unsigned Width = 66,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = do_push ? wptr_q + PtrOne : wptr_q;
    rptr_d = do_pop  ? rptr_q + PtrOne : rptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uf_axis_packer.sv
// Frames union-find records into tagged 64-bit beats plus a per-frame trailer beat.
module uf_axis_packer
  import uf_axis_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FIDX_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_s_valid,
  input  logic [35:0] i_s_data,
  input  logic        i_s_fstart,
  input  logic        i_s_last,
  output logic        o_s_ready,
  output logic        o_m_valid,
  output logic [63:0] o_m_data,
  output logic [7:0]  o_m_keep,
  output logic        o_m_user,
  output logic        o_m_last,
  input  logic        i_m_ready,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_trunc_cnt
);
  state_e            state_q, state_d;
  logic [FIDX_W-1:0] fidx_q, fidx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trunc_q, trunc_d;
  logic [15:0]       drop_q, drop_d, tcnt_q, tcnt_d;

  logic              s_ready, fifo_push, fifo_full, fifo_empty, miss_last;
  logic [65:0]       fifo_wdata, fifo_rdata;
  logic [15:0]       fidx16;

  assign fidx16 = 16'(fidx_q);

  always_comb begin
    state_d    = state_q;
    fidx_d     = fidx_q;
    cnt_d      = cnt_q;
    trunc_d    = trunc_q;
    drop_d     = drop_q;
    tcnt_d     = tcnt_q;
    s_ready    = 1'b0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    miss_last  = i_s_valid & i_s_fstart;
    unique case (state_q)
      StIdle: begin
        s_ready = ~fifo_full;
        if (i_s_valid && s_ready) begin
          if (i_s_fstart) begin
            fifo_push  = 1'b1;
            fifo_wdata = {1'b1, 1'b0, rec_beat(fidx16, 1'b1, i_s_data)};
            cnt_d      = CNT_W'(1);
            state_d    = i_s_last ? StTrailer : StStream;
          end else begin
            drop_d = sat_inc16(drop_q);
          end
        end
      end
      StStream: begin
        s_ready = ~fifo_full & ~miss_last;
        // A new fstart closes the open frame even when no slot is free.
        if (miss_last) begin
          trunc_d = 1'b1;
          tcnt_d  = sat_inc16(tcnt_q);
          state_d = StTrailer;
        end else if (i_s_valid && s_ready) begin
          fifo_push  = 1'b1;
          fifo_wdata = {1'b0, 1'b0, rec_beat(fidx16, 1'b0, i_s_data)};
          cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (i_s_last) state_d = StTrailer;
        end
      end
      StTrailer: begin
        if (!fifo_full) begin
          fifo_push  = 1'b1;
          fifo_wdata = {1'b0, 1'b1, trl_beat(fidx16, trunc_q, 32'(cnt_q))};
          fidx_d     = fidx_q + FIDX_W'(1);
          cnt_d      = '0;
          trunc_d    = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fidx_q  <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
      drop_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      drop_q  <= drop_d;
      tcnt_q  <= tcnt_d;
    end
  end

  uf_pack_fifo #(
    .Width(66),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (i_m_ready),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Head contents are masked while empty so idle outputs read as zero.
  assign o_s_ready   = s_ready & rst_n;
  assign o_m_valid   = ~fifo_empty;
  assign o_m_user    = ~fifo_empty & fifo_rdata[65];
  assign o_m_last    = ~fifo_empty & fifo_rdata[64];
  assign o_m_data    = fifo_empty ? 64'd0 : fifo_rdata[63:0];
  assign o_m_keep    = 8'hFF;
  assign o_drop_cnt  = drop_q;
  assign o_trunc_cnt = tcnt_q;

endmodule

// File: tb/tb_uf_axis_packer.sv
// Directed bench for uf_axis_packer: vector table plus backpressure and reset sequences.
module tb_uf_axis_packer;
  logic        clk = 1'b0;
  logic        rst_n, i_s_valid, i_s_fstart, i_s_last, i_m_ready;
  logic [35:0] i_s_data;
  logic        o_s_ready, o_m_valid, o_m_user, o_m_last;
  logic [63:0] o_m_data;
  logic [7:0]  o_m_keep;
  logic [15:0] o_drop_cnt, o_trunc_cnt;

  always #5 clk = ~clk;

  uf_axis_packer #(
    .FIFO_DEPTH(4),
    .CNT_W     (32),
    .FIDX_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_s_valid  (i_s_valid),
    .i_s_data   (i_s_data),
    .i_s_fstart (i_s_fstart),
    .i_s_last   (i_s_last),
    .o_s_ready  (o_s_ready),
    .o_m_valid  (o_m_valid),
    .o_m_data   (o_m_data),
    .o_m_keep   (o_m_keep),
    .o_m_user   (o_m_user),
    .o_m_last   (o_m_last),
    .i_m_ready  (i_m_ready),
    .o_drop_cnt (o_drop_cnt),
    .o_trunc_cnt(o_trunc_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v, fs, ls;
    logic [35:0] d;
    logic        rdy, mv, user, last;
    logic [63:0] data;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic fs, input logic ls,
                              input logic [35:0] d, input logic rdy, input logic mv,
                              input logic user, input logic last, input logic [63:0] data);
    vec_t r;
    r.v = v; r.fs = fs; r.ls = ls; r.d = d; r.rdy = rdy;
    r.mv = mv; r.user = user; r.last = last; r.data = data;
    return r;
  endfunction

  vec_t        tbl [14];
  logic [63:0] exp_b [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc_drop, got;
    // Table runs with i_m_ready=1, so each pushed beat shows one cycle after acceptance.
    tbl[0]  = mk(1, 1, 0, 36'h0_0000_0001, 1, 1, 1, 0, 64'h1000_0010_0000_0001);
    tbl[1]  = mk(1, 0, 0, 36'h0_0000_0002, 1, 1, 0, 0, 64'h1000_0000_0000_0002);
    tbl[2]  = mk(1, 0, 1, 36'h0_0000_0003, 1, 1, 0, 0, 64'h1000_0000_0000_0003);
    tbl[3]  = mk(0, 0, 0, 36'h0,           0, 1, 0, 1, 64'hF000_0000_0000_0003);
    tbl[4]  = mk(1, 1, 1, 36'hA_BCDE_F012, 1, 1, 1, 0, 64'h1000_101A_BCDE_F012);
    tbl[5]  = mk(0, 0, 0, 36'h0,           0, 1, 0, 1, 64'hF000_1000_0000_0001);
    tbl[6]  = mk(1, 0, 0, 36'h0_0000_0005, 1, 0, 0, 0, 64'h0);
    tbl[7]  = mk(1, 1, 0, 36'h0_0000_0007, 1, 1, 1, 0, 64'h1000_2010_0000_0007);
    tbl[8]  = mk(1, 0, 0, 36'h0_0000_0008, 1, 1, 0, 0, 64'h1000_2000_0000_0008);
    tbl[9]  = mk(1, 1, 0, 36'h0_0000_0009, 0, 0, 0, 0, 64'h0);
    tbl[10] = mk(1, 1, 0, 36'h0_0000_0009, 0, 1, 0, 1, 64'hF000_2100_0000_0002);
    tbl[11] = mk(1, 1, 0, 36'h0_0000_0009, 1, 1, 1, 0, 64'h1000_3010_0000_0009);
    tbl[12] = mk(1, 0, 1, 36'h0_0000_000A, 1, 1, 0, 0, 64'h1000_3000_0000_000A);
    tbl[13] = mk(0, 0, 0, 36'h0,           0, 1, 0, 1, 64'hF000_3000_0000_0002);

    rst_n = 1'b0; i_s_valid = 1'b0; i_s_fstart = 1'b0; i_s_last = 1'b0;
    i_s_data = '0; i_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(o_s_ready), 64'd0);
    check("rst_m_valid", 64'(o_m_valid), 64'd0);
    check("rst_m_data", o_m_data, 64'd0);
    check("rst_user_last", 64'({o_m_user, o_m_last}), 64'd0);
    check("rst_cnts", 64'({o_drop_cnt, o_trunc_cnt}), 64'd0);
    check("m_keep", 64'(o_m_keep), 64'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_s_valid = 1'b1; i_s_fstart = 1'b0; i_s_last = 1'b0; i_s_data = 36'(16 + i);
      #1;
      check("drop_ready", 64'(o_s_ready), 64'd1);
      @(posedge clk);
      #1;
      check("drop_no_out", 64'(o_m_valid), 64'd0);
    end
    @(negedge clk);
    i_s_valid = 1'b0;
    #1;
    check("drop_cnt5", 64'(o_drop_cnt), 64'd5);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      i_s_valid = tbl[i].v; i_s_fstart = tbl[i].fs; i_s_last = tbl[i].ls; i_s_data = tbl[i].d;
      #1;
      check($sformatf("vec%0d_ready", i), 64'(o_s_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 64'(o_m_valid), 64'(tbl[i].mv));
      check($sformatf("vec%0d_data", i), o_m_data, tbl[i].data);
      check($sformatf("vec%0d_user_last", i), 64'({o_m_user, o_m_last}),
            64'({tbl[i].user, tbl[i].last}));
    end
    @(negedge clk);
    i_s_valid = 1'b0; i_s_fstart = 1'b0;
    #1;
    check("drop_cnt6", 64'(o_drop_cnt), 64'd6);
    check("trunc_cnt1", 64'(o_trunc_cnt), 64'd1);

    // Backpressure: frame index 4, six records, sink stalled for 20 cycles.
    for (int i = 0; i < 6; i++) exp_b[i] = {4'h1, 16'd4, 7'd0, (i == 0), 36'(256 + i)};
    exp_b[6] = {4'hF, 16'd4, 3'd0, 1'b0, 8'd0, 32'd6};
    acc = 0; acc_drop = -1; got = 0;
    for (int cyc = 0; cyc < 200 && got < 7; cyc++) begin
      @(negedge clk);
      i_m_ready  = (cyc >= 20);
      i_s_valid  = (acc < 6);
      i_s_fstart = (acc == 0);
      i_s_last   = (acc == 5);
      i_s_data   = 36'(256 + acc);
      #1;
      if (!o_s_ready && acc_drop < 0 && cyc < 20) acc_drop = acc;
      if (cyc >= 1 && cyc < 20) check("bp_hold_data", o_m_data, exp_b[0]);
      if (cyc >= 4 && cyc < 20) check("bp_ready_low", 64'(o_s_ready), 64'd0);
      if (o_m_valid && i_m_ready) begin
        check($sformatf("bp_beat%0d", got), o_m_data, exp_b[got]);
        check($sformatf("bp_last%0d", got), 64'(o_m_last), 64'(got == 6));
        got++;
      end
      if (i_s_valid && o_s_ready) acc++;
      @(posedge clk);
    end
    check("bp_accept_before_full", 64'(acc_drop), 64'd4);
    check("bp_beats_out", 64'(got), 64'd7);
    check("bp_records_in", 64'(acc), 64'd6);

    // Reset mid-frame with beats still queued.
    @(negedge clk);
    i_m_ready = 1'b0; i_s_valid = 1'b1; i_s_fstart = 1'b1; i_s_last = 1'b0; i_s_data = 36'h200;
    @(negedge clk);
    i_s_fstart = 1'b0; i_s_data = 36'h201;
    @(negedge clk);
    i_s_data = 36'h202; rst_n = 1'b0;
    #1;
    check("rstmid_ready", 64'(o_s_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rstmid_valid", 64'(o_m_valid), 64'd0);
    check("rstmid_data", o_m_data, 64'd0);
    check("rstmid_user_last", 64'({o_m_user, o_m_last}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; i_s_valid = 1'b0; i_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rstmid_no_trailer", 64'(o_m_valid), 64'd0);
    end
    @(negedge clk);
    i_s_valid = 1'b1; i_s_fstart = 1'b1; i_s_last = 1'b1; i_s_data = 36'h55;
    @(posedge clk);
    #1;
    check("post_rst_rec", o_m_data, 64'h1000_0010_0000_0055);
    check("post_rst_user", 64'(o_m_user), 64'd1);
    @(negedge clk);
    i_s_valid = 1'b0; i_s_fstart = 1'b0; i_s_last = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_trl", o_m_data, 64'hF000_0000_0000_0001);
    check("post_rst_last", 64'(o_m_last), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
